// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: PC increment,
// jump-field width and the encoding of where the next PC comes from.
package pc_seq_pkg;

    localparam int PC_INC   = 4;
    localparam int JFIELD_W = 26;

    typedef enum logic [2:0] {
        SRC_HOLD,
        SRC_SEQ,
        SRC_BR,
        SRC_J,
        SRC_JR
    } pc_src_e;

endpackage

// File: rtl/pc_seq_ras.sv
// Circular return-address stack used as a prediction hint by pc_sequencer.
// A push onto a full stack overwrites the oldest entry; a pop on an empty
// stack does nothing. Only built when PC_SEQ_RAS_EN is defined.
module pc_seq_ras #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             Reset_L,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_pushData,
    output logic [WIDTH-1:0] o_top,
    output logic             o_valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_stack [DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_pushPtr;

    assign w_pushPtr = r_ptr + 1'b1;

    // Top pointer and occupancy; pop wins, and the count saturates when full
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (i_pop) begin
            if (r_count != '0) begin
                r_ptr   <= r_ptr - 1'b1;
                r_count <= r_count - 1'b1;
            end
        end else if (i_push) begin
            r_ptr <= w_pushPtr;
            if (r_count != FULL_COUNT) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Entry storage; contents are masked by the count so it needs no reset
    always_ff @(posedge CLK) begin
        if (i_push && !i_pop) begin
            r_stack[w_pushPtr] <= i_pushData;
        end
    end

    assign o_valid = (r_count != '0);
    assign o_top   = o_valid ? r_stack[r_ptr] : '0;

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with next-PC selection for sequential flow,
// BEQ/BNE branches, J/JAL and JR, plus stall hold and link address.
// Optional return-address stack enabled by defining PC_SEQ_RAS_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int          PC_WIDTH  = 32,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          RAS_DEPTH = 4
) (
    input  logic                CLK,
    input  logic                Reset_L,
    input  logic                Stall,
    input  logic                Branch,
    input  logic                BranchNE,
    input  logic                ALUZero,
    input  logic                Jump,
    input  logic                JumpLink,
    input  logic                JumpReg,
    input  logic [JFIELD_W-1:0] JumpField,
    input  logic [31:0]         SignExtImm32,
    input  logic [PC_WIDTH-1:0] JumpRegTarget,
    output logic [PC_WIDTH-1:0] PC,
    output logic [PC_WIDTH-1:0] NextPC,
    output logic [PC_WIDTH-1:0] LinkAddr,
    output logic                Redirect,
    output logic                TargetMisalign,
    output logic [PC_WIDTH-1:0] RasTop,
    output logic                RasValid
);

    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_pc4;
    logic [PC_WIDTH-1:0] w_jTarget;
    logic [PC_WIDTH-1:0] w_jrTarget;
    logic [PC_WIDTH-1:0] w_brTarget;
    logic [31:0]         w_brOffset32;
    logic                w_brTaken;
    pc_src_e             w_src;

    assign w_pc4        = r_pc + PC_WIDTH'(PC_INC);
    assign w_jTarget    = {w_pc4[PC_WIDTH-1:28], JumpField, 2'b00};
    assign w_jrTarget   = {JumpRegTarget[PC_WIDTH-1:2], 2'b00};
    assign w_brOffset32 = SignExtImm32 << 2;
    assign w_brTarget   = w_pc4 + w_brOffset32[PC_WIDTH-1:0];
    assign w_brTaken    = Branch & (ALUZero ^ BranchNE);

    // Pick the next-PC source: stall, then JR, then J, then taken branch
    always_comb begin
        w_src = SRC_SEQ;
        if (Stall) begin
            w_src = SRC_HOLD;
        end else if (JumpReg) begin
            w_src = SRC_JR;
        end else if (Jump) begin
            w_src = SRC_J;
        end else if (w_brTaken) begin
            w_src = SRC_BR;
        end
    end

    // Steer the selected source onto NextPC
    always_comb begin
        NextPC = w_pc4;
        case (w_src)
            SRC_HOLD: NextPC = r_pc;
            SRC_JR:   NextPC = w_jrTarget;
            SRC_J:    NextPC = w_jTarget;
            SRC_BR:   NextPC = w_brTarget;
            default:  NextPC = w_pc4;
        endcase
    end

    // Architectural PC register, one update per cycle
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_pc <= RESET_PC[PC_WIDTH-1:0];
        end else begin
            r_pc <= NextPC;
        end
    end

    assign PC             = r_pc;
    assign LinkAddr       = w_pc4;
    assign Redirect       = !Stall && (NextPC != w_pc4);
    assign TargetMisalign = JumpReg & (|JumpRegTarget[1:0]);

`ifdef PC_SEQ_RAS_EN
    logic w_rasPush;
    logic w_rasPop;

    // A JR in the same cycle as a JAL suppresses the JAL, so only the pop happens
    assign w_rasPush = Jump & JumpLink & ~JumpReg & ~Stall;
    assign w_rasPop  = JumpReg & ~Stall;

    pc_seq_ras #(
        .WIDTH (PC_WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .CLK        (CLK),
        .Reset_L    (Reset_L),
        .i_push     (w_rasPush),
        .i_pop      (w_rasPop),
        .i_pushData (w_pc4),
        .o_top      (RasTop),
        .o_valid    (RasValid)
    );
`else
    // Without the stack JumpLink and RAS_DEPTH have no effect; both fold to a constant 0
    assign RasTop   = '0;
    assign RasValid = JumpLink & (RAS_DEPTH < 0);
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random
// cycles compared against a behavioural PC/return-stack model.
module tb_pc_sequencer;

    localparam int PC_WIDTH  = 32;
    localparam int RAS_DEPTH = 4;
`ifdef PC_SEQ_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        Reset_L;
    logic        Stall, Branch, BranchNE, ALUZero, Jump, JumpLink, JumpReg;
    logic [25:0] JumpField;
    logic [31:0] SignExtImm32;
    logic [31:0] JumpRegTarget;
    logic [31:0] PC, NextPC, LinkAddr, RasTop;
    logic        Redirect, TargetMisalign, RasValid;

    int checks = 0;
    int errors = 0;

    logic [31:0] mPc;
    logic [31:0] rasQ [$];

    pc_sequencer #(
        .PC_WIDTH  (PC_WIDTH),
        .RESET_PC  (32'h0),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .CLK            (CLK),
        .Reset_L        (Reset_L),
        .Stall          (Stall),
        .Branch         (Branch),
        .BranchNE       (BranchNE),
        .ALUZero        (ALUZero),
        .Jump           (Jump),
        .JumpLink       (JumpLink),
        .JumpReg        (JumpReg),
        .JumpField      (JumpField),
        .SignExtImm32   (SignExtImm32),
        .JumpRegTarget  (JumpRegTarget),
        .PC             (PC),
        .NextPC         (NextPC),
        .LinkAddr       (LinkAddr),
        .Redirect       (Redirect),
        .TargetMisalign (TargetMisalign),
        .RasTop         (RasTop),
        .RasValid       (RasValid)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic br, input logic bne, input logic z,
                                 input logic j, input logic jl, input logic jr,
                                 input logic [25:0] f, input logic [31:0] imm, input logic [31:0] t);
        Stall = st; Branch = br; BranchNE = bne; ALUZero = z;
        Jump = j; JumpLink = jl; JumpReg = jr;
        JumpField = f; SignExtImm32 = imm; JumpRegTarget = t;
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 26'h0, 32'h0, 32'h0);
    endtask

    // Expected next PC straight from the priority rules, on plain 32-bit arithmetic
    function automatic logic [31:0] modelNext();
        logic [31:0] seq;
        seq = mPc + 32'd4;
        if (Stall)   return mPc;
        if (JumpReg) return JumpRegTarget & 32'hFFFF_FFFC;
        if (Jump)    return (seq & 32'hF000_0000) | ({6'b0, JumpField} * 32'd4);
        if (Branch && (ALUZero != BranchNE)) return seq + SignExtImm32 * 32'd4;
        return seq;
    endfunction

    task automatic checkRas(input string tag);
        logic [31:0] expTop;
        logic        expValid;
        expValid = RAS_EN && (rasQ.size() > 0);
        expTop   = expValid ? rasQ[$] : 32'h0;
        checkOutput({tag, ".RasValid"}, {31'b0, RasValid}, {31'b0, expValid});
        checkOutput({tag, ".RasTop"}, RasTop, expTop);
    endtask

    task automatic checkComb(input string tag);
        logic [31:0] exp;
        logic        expRedir, expMis;
        exp      = modelNext();
        expRedir = !Stall && (exp != mPc + 32'd4);
        expMis   = JumpReg && (JumpRegTarget[1:0] != 2'b00);
        checkOutput({tag, ".NextPC"}, NextPC, exp);
        checkOutput({tag, ".LinkAddr"}, LinkAddr, mPc + 32'd4);
        checkOutput({tag, ".Redirect"}, {31'b0, Redirect}, {31'b0, expRedir});
        checkOutput({tag, ".TargetMisalign"}, {31'b0, TargetMisalign}, {31'b0, expMis});
        checkRas(tag);
    endtask

    task automatic clockEdge(input string tag);
        logic [31:0] nxt;
        nxt = modelNext();
        if (!Stall) begin
            if (JumpReg) begin
                if (rasQ.size() > 0) void'(rasQ.pop_back());
            end else if (Jump && JumpLink) begin
                rasQ.push_back(mPc + 32'd4);
                if (rasQ.size() > RAS_DEPTH) void'(rasQ.pop_front());
            end
        end
        @(posedge CLK);
        #1;
        mPc = nxt;
        checkOutput({tag, ".PC"}, PC, mPc);
        checkRas({tag, ".post"});
    endtask

    task automatic jumpTo(input logic [31:0] target);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 26'h0, 32'h0, target);
        clockEdge("jr");
    endtask

    task automatic modelReset();
        mPc = 32'h0;
        rasQ.delete();
    endtask

    initial begin
        Reset_L = 1'b0;
        idle();
        modelReset();
        #11;
        checkOutput("reset.PC", PC, 32'h0);
        checkComb("reset");
        Reset_L = 1'b1;

        // Run sequentially up to 0x40
        repeat (16) begin
            idle();
            checkComb("seq");
            clockEdge("seq");
        end
        checkOutput("t1.pcBefore", PC, 32'h40);

        // Asynchronous reset mid-cycle
        #2;
        Reset_L = 1'b0;
        #1;
        modelReset();
        checkOutput("t1.asyncReset", PC, 32'h0);
        #1;
        Reset_L = 1'b1;
        idle();
        clockEdge("t1a");
        checkOutput("t1.pc4", PC, 32'h4);
        clockEdge("t1b");
        checkOutput("t1.pc8", PC, 32'h8);
        clockEdge("t1c");
        checkOutput("t1.pcC", PC, 32'hC);

        // Branch taken / not taken
        jumpTo(32'h100);
        applyStimulus(0, 1, 0, 1, 0, 0, 0, 26'h0, 32'hFFFF_FFFE, 32'h0);
        checkComb("t2taken");
        checkOutput("t2.takenNext", NextPC, 32'h0FC);
        checkOutput("t2.takenRedir", {31'b0, Redirect}, 32'h1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 26'h0, 32'hFFFF_FFFE, 32'h0);
        checkComb("t2fall");
        checkOutput("t2.fallNext", NextPC, 32'h104);
        checkOutput("t2.fallRedir", {31'b0, Redirect}, 32'h0);
        idle();
        clockEdge("t2");

        // Jump region bits, then JR overriding the jump
        jumpTo(32'h1000_0010);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 26'h0000040, 32'h0, 32'h0);
        checkComb("t3j");
        checkOutput("t3.jNext", NextPC, 32'h1000_0100);
        applyStimulus(0, 0, 0, 0, 1, 0, 1, 26'h0000040, 32'h0, 32'h203);
        checkComb("t3jr");
        checkOutput("t3.jrNext", NextPC, 32'h200);
        checkOutput("t3.misalign", {31'b0, TargetMisalign}, 32'h1);
        clockEdge("t3");

        // Stall holds the PC even with a pending jump
        repeat (3) begin
            applyStimulus(1, 0, 0, 0, 1, 0, 0, 26'h0000100, 32'h0, 32'h0);
            checkComb("t4stall");
            checkOutput("t4.stallRedir", {31'b0, Redirect}, 32'h0);
            clockEdge("t4stall");
            checkOutput("t4.hold", PC, 32'h200);
        end
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 26'h0000100, 32'h0, 32'h0);
        checkComb("t4go");
        clockEdge("t4go");
        checkOutput("t4.jumped", PC, 32'h400);

        // Wrap from the last word to zero
        jumpTo(32'hFFFF_FFFC);
        idle();
        checkComb("t5");
        clockEdge("t5");
        checkOutput("t5.wrap", PC, 32'h0);

        // Random control mix against the model
        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 5) == 0, 26'($urandom),
                          $urandom, $urandom);
            checkComb("rand");
            clockEdge("rand");
        end

`ifdef PC_SEQ_RAS_EN
        // Return stack: five calls overflow depth 4, then unwind
        idle();
        #1;
        Reset_L = 1'b0;
        #1;
        modelReset();
        Reset_L = 1'b1;
        checkOutput("t6.emptyValid", {31'b0, RasValid}, 32'h0);
        jumpTo(32'h10);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(0, 0, 0, 0, 1, 1, 0, 26'(((k + 1) * 16) / 4), 32'h0, 32'h0);
            checkComb("t6call");
            clockEdge("t6call");
        end
        checkOutput("t6.top54", RasTop, 32'h54);
        checkOutput("t6.valid", {31'b0, RasValid}, 32'h1);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 1, 26'h0, 32'h0, 32'h80);
            checkComb("t6ret");
            clockEdge("t6ret");
            if (k == 0) checkOutput("t6.top44", RasTop, 32'h44);
            if (k == 1) checkOutput("t6.top34", RasTop, 32'h34);
            if (k == 2) checkOutput("t6.top24", RasTop, 32'h24);
            if (k >= 3) checkOutput("t6.empty", {31'b0, RasValid}, 32'h0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
